// File: rtl/vec_id_ex_reg_pkg.sv
// Types and helpers shared by the vector ID/EX boundary register.
`include "constants.vh"

package vec_id_ex_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } id_ex_state_e;

    function automatic logic funct3_is_legal(input logic [2:0] funct3);
        return (funct3 == `VV_FORMAT) || (funct3 == `VX_FORMAT) || (funct3 == `VI_FROMAT);
    endfunction

endpackage

// File: rtl/constants.vh
// Shared vector funct3 format encodings and the packed ID/EX entry width.
`ifndef VEC_CONSTANTS_VH
`define VEC_CONSTANTS_VH

`define VV_FORMAT 3'b000
`define VX_FORMAT 3'b100
`define VI_FROMAT 3'b011

`define VEC_ENTRY_W (3+FUNCT6_W+1+VREG_AW+2*DATA_W+1)

`endif

// File: rtl/vec_pipe_entry.sv
// One pipeline slot: valid bit plus payload, with load and clear (clear wins).
module vec_pipe_entry #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/vec_id_ex_reg.sv
// Registered ID->EX boundary: MAIN drives EX, SKID absorbs one op so in_ready can be a flop.
`include "constants.vh"

module vec_id_ex_reg
    import vec_id_ex_reg_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned VREG_AW  = 5,
    parameter int unsigned FUNCT6_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_funct3,
    input  logic [FUNCT6_W-1:0] in_funct6,
    input  logic                in_vm,
    input  logic [VREG_AW-1:0]  in_vd,
    input  logic [DATA_W-1:0]   in_dataA_64,
    input  logic [DATA_W-1:0]   in_dataB_64,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2:0]          out_funct3,
    output logic [FUNCT6_W-1:0] out_funct6,
    output logic                out_vm,
    output logic [VREG_AW-1:0]  out_vd,
    output logic [DATA_W-1:0]   out_dataA_64,
    output logic [DATA_W-1:0]   out_dataB_64,
    output logic                out_illegal
);

    localparam int unsigned ENTRY_W = `VEC_ENTRY_W;

    logic               in_ready_q, in_ready_d;
    logic               main_valid, skid_valid;
    logic [ENTRY_W-1:0] main_data, skid_data, in_entry, main_data_in;
    logic               main_load, main_clr, main_from_skid;
    logic               skid_load, skid_clr;
    logic               accept, issue;
    id_ex_state_e       state_q, state_d;

    assign accept   = in_valid & in_ready_q;
    assign issue    = main_valid & out_ready;
    assign in_entry = {in_funct3, in_funct6, in_vm, in_vd, in_dataA_64, in_dataB_64,
                       ~funct3_is_legal(in_funct3)};

    // The state lives in the two entry valid bits; this just names it.
    always_comb begin
        state_q = ST_EMPTY;
        if (skid_valid)      state_q = ST_FULL;
        else if (main_valid) state_q = ST_ONE;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_ONE;
                ST_ONE: begin
                    if (accept && !issue)      state_d = ST_FULL;
                    else if (issue && !accept) state_d = ST_EMPTY;
                end
                ST_FULL:  if (issue) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = (state_d != ST_FULL);
    end

    always_comb begin
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: main_load = accept;
                ST_ONE: begin
                    if (accept && issue) main_load = 1'b1;
                    else if (accept)     skid_load = 1'b1;
                    else if (issue)      main_clr  = 1'b1;
                end
                ST_FULL: begin
                    if (issue) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: begin
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_ready_q <= 1'b1;
        else        in_ready_q <= in_ready_d;
    end

    assign main_data_in = main_from_skid ? skid_data : in_entry;

    vec_pipe_entry #(.W(ENTRY_W)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (main_load),
        .clear_i (main_clr),
        .data_i  (main_data_in),
        .valid_o (main_valid),
        .data_o  (main_data)
    );

    vec_pipe_entry #(.W(ENTRY_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .data_i  (in_entry),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign {out_funct3, out_funct6, out_vm, out_vd, out_dataA_64, out_dataB_64, out_illegal} = main_data;

endmodule

// File: tb/tb_vec_id_ex_reg.sv
// Randomized and directed bench for vec_id_ex_reg against a two-deep queue model.
module tb_vec_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = '0;
    logic [5:0]  in_funct6 = '0;
    logic        in_vm = 1'b0;
    logic [4:0]  in_vd = '0;
    logic [63:0] in_dataA_64 = '0;
    logic [63:0] in_dataB_64 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_funct3;
    logic [5:0]  out_funct6;
    logic        out_vm;
    logic [4:0]  out_vd;
    logic [63:0] out_dataA_64;
    logic [63:0] out_dataB_64;
    logic        out_illegal;

    always #5 clk = ~clk;

    vec_id_ex_reg #(.DATA_W(64), .VREG_AW(5), .FUNCT6_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_funct3    (in_funct3),
        .in_funct6    (in_funct6),
        .in_vm        (in_vm),
        .in_vd        (in_vd),
        .in_dataA_64  (in_dataA_64),
        .in_dataB_64  (in_dataB_64),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_funct3   (out_funct3),
        .out_funct6   (out_funct6),
        .out_vm       (out_vm),
        .out_vd       (out_vd),
        .out_dataA_64 (out_dataA_64),
        .out_dataB_64 (out_dataB_64),
        .out_illegal  (out_illegal)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [5:0]  f6;
        logic        vm;
        logic [4:0]  vd;
        logic [63:0] a;
        logic [63:0] b;
    } op_t;

    op_t mq[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // RVV encodings: OPIVV, OPIVX, OPIVI are the only supported formats.
    function automatic logic model_illegal(input logic [2:0] f3);
        return !(f3 == 3'b000 || f3 == 3'b100 || f3 == 3'b011);
    endfunction

    task automatic check_outputs();
        check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        if (mq.size() > 0) begin
            check("out_funct3", 64'(out_funct3), 64'(mq[0].f3));
            check("out_funct6", 64'(out_funct6), 64'(mq[0].f6));
            check("out_vm", 64'(out_vm), 64'(mq[0].vm));
            check("out_vd", 64'(out_vd), 64'(mq[0].vd));
            check("out_dataA", out_dataA_64, mq[0].a);
            check("out_dataB", out_dataB_64, mq[0].b);
            check("out_illegal", 64'(out_illegal), 64'(model_illegal(mq[0].f3)));
        end
    endtask

    // One clock: check outputs at negedge, drive inputs, advance model at posedge.
    task automatic step(input logic fl, input logic iv, input logic ordy, input op_t op,
                        output logic acc);
        logic iss;
        @(negedge clk);
        check_outputs();
        flush       = fl;
        in_valid    = iv;
        out_ready   = ordy;
        in_funct3   = op.f3;
        in_funct6   = op.f6;
        in_vm       = op.vm;
        in_vd       = op.vd;
        in_dataA_64 = op.a;
        in_dataB_64 = op.b;
        @(posedge clk);
        iss = (mq.size() > 0) && ordy;
        acc = iv && (mq.size() < 2) && !fl;
        if (fl) begin
            mq.delete();
        end else begin
            if (iss) void'(mq.pop_front());
            if (acc) mq.push_back(op);
        end
    endtask

    function automatic op_t rand_op();
        op_t o;
        o.f3 = 3'($urandom_range(0, 7));
        o.f6 = 6'($urandom);
        o.vm = 1'($urandom);
        o.vd = 5'($urandom);
        o.a  = {$urandom, $urandom};
        o.b  = {$urandom, $urandom};
        return o;
    endfunction

    function automatic op_t mk_op(input logic [2:0] f3, input logic [4:0] vd, input logic [63:0] a);
        op_t o;
        o = rand_op();
        o.f3 = f3;
        o.vd = vd;
        o.a  = a;
        return o;
    endfunction

    task automatic offer_until_taken(input logic ordy, input op_t op, input int unsigned budget);
        logic acc;
        acc = 1'b0;
        for (int unsigned i = 0; i < budget && !acc; i++) step(1'b0, 1'b1, ordy, op, acc);
        check("offer_taken", 64'(acc), 64'd1);
    endtask

    op_t idle_op;
    logic acc;

    initial begin
        idle_op = mk_op(3'b000, 5'd0, 64'd0);

        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_dataA", out_dataA_64, 64'd0);
        check("rst_illegal", 64'(out_illegal), 64'd0);
        rst_n = 1'b1;

        // Single VV op, EX ready.
        step(1'b0, 1'b1, 1'b1, mk_op(3'b000, 5'd5, 64'h0123_4567_89AB_CDEF), acc);
        step(1'b0, 1'b0, 1'b1, idle_op, acc);
        step(1'b0, 1'b0, 1'b1, idle_op, acc);

        // Back-to-back stream of 8.
        for (int unsigned i = 0; i < 8; i++)
            step(1'b0, 1'b1, 1'b1, mk_op(3'b100, 5'(i), 64'(i + 100)), acc);
        repeat (2) step(1'b0, 1'b0, 1'b1, idle_op, acc);

        // Backpressure with three offered ops.
        offer_until_taken(1'b0, mk_op(3'b011, 5'd1, 64'd1), 4);
        offer_until_taken(1'b0, mk_op(3'b011, 5'd2, 64'd2), 4);
        repeat (3) step(1'b0, 1'b1, 1'b0, mk_op(3'b011, 5'd3, 64'd3), acc);
        offer_until_taken(1'b1, mk_op(3'b011, 5'd3, 64'd3), 4);
        repeat (3) step(1'b0, 1'b0, 1'b1, idle_op, acc);

        // Flush while FULL with a concurrent input.
        step(1'b0, 1'b1, 1'b0, rand_op(), acc);
        step(1'b0, 1'b1, 1'b0, rand_op(), acc);
        step(1'b1, 1'b1, 1'b0, rand_op(), acc);
        repeat (2) step(1'b0, 1'b0, 1'b1, idle_op, acc);

        // Unsupported funct3.
        step(1'b0, 1'b1, 1'b1, mk_op(3'b111, 5'd9, 64'd0), acc);
        repeat (2) step(1'b0, 1'b0, 1'b1, idle_op, acc);

        // Randomized traffic.
        for (int unsigned i = 0; i < 800; i++)
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 6), rand_op(), acc);
        repeat (3) step(1'b0, 1'b0, 1'b1, idle_op, acc);

        // Asynchronous reset mid-cycle while FULL.
        step(1'b0, 1'b1, 1'b0, rand_op(), acc);
        step(1'b0, 1'b1, 1'b0, rand_op(), acc);
        @(negedge clk);
        check("pre_areset_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("areset_out_valid", 64'(out_valid), 64'd0);
        check("areset_in_ready", 64'(in_ready), 64'd1);
        check("areset_dataA", out_dataA_64, 64'd0);
        check("areset_funct3", 64'(out_funct3), 64'd0);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step(1'b0, 1'b0, 1'b1, idle_op, acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vec_id_ex_reg.md
Name: vec_id_ex_reg

Overview:
- Registered ID→EX boundary for the vector datapath.
- Sits directly downstream of the 64-bit operand-A selector and captures the selected operand A, operand B, and decoded op fields.
- Presents them to the vector execute stage through a valid/ready handshake.
- A 2-entry skid buffer lets `in_ready` be purely registered while sustaining one op per cycle. A synchronous flush squashes in-flight ops on redirect.

Parameters:
- DATA_W, 64, operand width
- VREG_AW, 5, vector register index width
- FUNCT6_W, 6, funct6 width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  squash all held ops (synchronous)
- in_valid  in  1  upstream op valid
- in_ready  out  1  block can accept; registered
- in_funct3  in  3  operand format
- in_funct6  in  FUNCT6_W  operation select
- in_vm  in  1  mask enable
- in_vd  in  VREG_AW  destination vector register
- in_dataA_64  in  DATA_W  selected operand A
- in_dataB_64  in  DATA_W  operand B (vs2 read)
- out_valid  out  1  op valid to EX
- out_ready  in  1  EX accepts
- out_funct3  out  3  held funct3
- out_funct6  out  FUNCT6_W  held funct6
- out_vm  out  1  held mask enable
- out_vd  out  VREG_AW  held vd
- out_dataA_64  out  DATA_W  held operand A
- out_dataB_64  out  DATA_W  held operand B
- out_illegal  out  1  held op had unsupported funct3

Behaviour:
- Reset (rst_n low, asynchronous):
  - Every register and output goes to 0, except in_ready, which is 1.
  - Reset mid-operation drops all held ops with no output.
- Storage is two entries: MAIN (drives out_*) and SKID. Each entry holds {funct3, funct6, vm, vd, dataA, dataB, illegal} plus a valid bit.
- States derived from the valid bits:
  - EMPTY: neither valid.
  - ONE: MAIN valid only.
  - FULL: MAIN and SKID valid.
  - SKID valid while MAIN invalid is unreachable.
- Handshakes:
  - accept = in_valid & in_ready.
  - issue = out_valid & out_ready.
  - out_valid = MAIN.valid.
  - in_ready = !SKID.valid, as a flop.
- Transitions (rising clk, flush low):
  - EMPTY + accept → ONE; MAIN loads input.
  - ONE + accept + issue → ONE; MAIN reloads from input.
  - ONE + accept, no issue → FULL; SKID loads input.
  - ONE + issue, no accept → EMPTY.
  - FULL + issue → ONE; MAIN loads from SKID. in_ready is 0, so no accept can occur.
  - FULL, no issue → hold.
- Latency: an input accepted in cycle N appears on out_* with out_valid=1 in cycle N+1 when the block is EMPTY or issuing. Throughput is 1 op/cycle with out_ready held high.
- Output stability: out_* is stable while out_valid=1 and out_ready=0.
- Flush:
  - Takes priority over accept and issue.
  - Next state is EMPTY; both valids clear and in_ready=1.
  - An input presented in the flush cycle is discarded.
  - An issue in the flush cycle is still counted as taken by EX; the squash is the EX stage's concern.
- illegal bit:
  - Computed at capture: 1 when in_funct3 ∉ {VV_FORMAT, VX_FORMAT, VI_FROMAT}.
  - Illegal ops are accepted and forwarded normally; dataA is passed as received (0 from the selector).
- No data transformation; widths pass straight through.

Decomposition:
- Format encodings stay in constants.vh: VV_FORMAT, VX_FORMAT, and VI_FROMAT, keeping the existing macro spelling.
- Add a single `define for the packed entry width: 3+FUNCT6_W+1+VREG_AW+2*DATA_W+1.
- The natural sub-module is vec_pipe_entry: a valid bit plus payload register with load/clear. Instantiate it twice, as MAIN and SKID.
- The control FSM stays in vec_id_ex_reg.

Test Plan:
- Reset release, then one VV op (funct3=VV_FORMAT, dataA=64'h0123_4567_89AB_CDEF, vd=5) with out_ready=1 → out_valid=1 exactly one cycle after accept, fields match, out_illegal=0, in_ready stays 1.
- Back-to-back stream of 8 ops with out_ready=1 → 8 consecutive out_valid cycles in order, no bubbles.
- Backpressure: out_ready=0 while 3 ops are offered (dataA=1,2,3).
  - Ops 1 and 2 are accepted; in_ready drops to 0 the cycle after op 2; op 3 is held by upstream.
  - Raising out_ready yields 1, 2, 3 in order; out_* is stable throughout the stall.
- Flush while FULL, with in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1; neither held op nor the flush-cycle input ever appears.
- Unsupported funct3=3'b111 with dataA=0 → forwarded with out_illegal=1.
- Asynchronous reset asserted mid-cycle while FULL → outputs clear immediately, without waiting for clk.
